// File: rtl/fb_port_arbiter_if.sv
// Requester and frame-buffer RAM bundle for fb_port_arbiter.
// slave = the arbiter; master = VGA/OLED/draw requesters plus the RAM model.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 18
);
    logic              vga_req;
    logic [8:0]        vga_x;
    logic [8:0]        vga_y;
    logic [DATA_W-1:0] vga_pixel;
    logic              vga_valid;
    logic              oled_req;
    logic [12:0]       oled_index;
    logic [DATA_W-1:0] oled_pixel;
    logic              oled_valid;
    logic              oled_overrun;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vga_req, vga_x, vga_y, oled_req, oled_index,
        input  wr_valid, wr_addr, wr_data, ram_rdata,
        output vga_pixel, vga_valid, oled_pixel, oled_valid, oled_overrun,
        output wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output vga_req, vga_x, vga_y, oled_req, oled_index,
        output wr_valid, wr_addr, wr_data, ram_rdata,
        input  vga_pixel, vga_valid, oled_pixel, oled_valid, oled_overrun,
        input  wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA > starved write > OLED > write; reads return 2 edges after grant.
// Writes stall via wr_ready; OLED holds one pending request and flags overrun when a second one arrives.
module fb_port_arbiter #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 18,
    parameter int OLED_W     = 96,
    parameter int OLED_H     = 64,
    parameter int OLED_X0    = 112,
    parameter int OLED_Y0    = 88,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    fb_port_arbiter_if.slave  bus
);
    localparam int COL_W  = $clog2(OLED_W);
    localparam int ROW_W  = $clog2(OLED_H);
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);

    if (FB_W * FB_H > (1 << ADDR_W) || OLED_X0 + OLED_W > FB_W || OLED_Y0 + OLED_H > FB_H) begin : g_geom_chk
        $error("fb_port_arbiter: frame buffer or OLED window geometry out of range");
    end

    typedef enum logic [1:0] {GNT_IDLE, GNT_VGA, GNT_OLED, GNT_WR} grant_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_OLED} tag_t;

    grant_t            grant;
    tag_t              tag0;
    tag_t              tag1;
    logic [SCNT_W-1:0] starve;
    logic              oled_pend;
    logic [ADDR_W-1:0] pend_addr;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  use_col;
    logic [COL_W-1:0]  nxt_col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  use_row;
    logic [ROW_W-1:0]  nxt_row;
    logic [ADDR_W-1:0] vga_addr;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] oled_addr;
    logic [DATA_W-1:0] rdata;
    logic              oled_take;
    logic              set_pend;

    always_comb begin
        grant = GNT_IDLE;
        if (bus.vga_req)
            grant = GNT_VGA;
        else if (bus.wr_valid && starve == SCNT_W'(STARVE_MAX))
            grant = GNT_WR;
        else if (oled_pend || bus.oled_req)
            grant = GNT_OLED;
        else if (bus.wr_valid)
            grant = GNT_WR;
    end

    assign bus.wr_ready = (grant == GNT_WR);

    // Index 0 restarts the window scan; any other index just follows the running col/row.
    assign use_col = (bus.oled_index == '0) ? '0 : col;
    assign use_row = (bus.oled_index == '0) ? '0 : row;
    assign nxt_col = (use_col == COL_W'(OLED_W - 1)) ? '0 : use_col + COL_W'(1);
    assign nxt_row = (use_col != COL_W'(OLED_W - 1)) ? use_row :
                     (use_row == ROW_W'(OLED_H - 1)) ? '0 : use_row + ROW_W'(1);

    assign vga_addr  = ADDR_W'(int'(bus.vga_y) * FB_W + int'(bus.vga_x));
    assign req_addr  = ADDR_W'((int'(use_row) + OLED_Y0) * FB_W + int'(use_col) + OLED_X0);
    assign oled_addr = oled_pend ? pend_addr : req_addr;
    assign rdata     = bus.ram_rdata;

    // A request is taken if the slot is free or the pending one is served this cycle;
    // it must be parked whenever it is taken but not itself the one being granted.
    assign oled_take = bus.oled_req && (!oled_pend || grant == GNT_OLED);
    assign set_pend  = bus.oled_req && (oled_pend == (grant == GNT_OLED));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_en       <= 1'b0;
            bus.ram_we       <= 1'b0;
            bus.ram_addr     <= '0;
            bus.ram_wdata    <= '0;
            bus.vga_pixel    <= '0;
            bus.vga_valid    <= 1'b0;
            bus.oled_pixel   <= '0;
            bus.oled_valid   <= 1'b0;
            bus.oled_overrun <= 1'b0;
            tag0             <= TAG_NONE;
            tag1             <= TAG_NONE;
            starve           <= '0;
            oled_pend        <= 1'b0;
            pend_addr        <= '0;
            col              <= '0;
            row              <= '0;
        end else begin
            bus.ram_en <= (grant != GNT_IDLE);
            bus.ram_we <= (grant == GNT_WR);
            case (grant)
                GNT_VGA:  bus.ram_addr <= vga_addr;
                GNT_OLED: bus.ram_addr <= oled_addr;
                GNT_WR: begin
                    bus.ram_addr  <= bus.wr_addr;
                    bus.ram_wdata <= bus.wr_data;
                end
                default: ;
            endcase

            case (grant)
                GNT_VGA:  tag0 <= TAG_VGA;
                GNT_OLED: tag0 <= TAG_OLED;
                default:  tag0 <= TAG_NONE;
            endcase
            tag1 <= tag0;

            bus.vga_valid  <= (tag1 == TAG_VGA);
            bus.oled_valid <= (tag1 == TAG_OLED);
            if (tag1 == TAG_VGA)
                bus.vga_pixel <= rdata;
            if (tag1 == TAG_OLED)
                bus.oled_pixel <= rdata;

            if (!bus.wr_valid || grant == GNT_WR)
                starve <= '0;
            else if (starve != SCNT_W'(STARVE_MAX))
                starve <= starve + SCNT_W'(1);

            if (set_pend) begin
                oled_pend <= 1'b1;
                pend_addr <= req_addr;
            end else if (grant == GNT_OLED) begin
                oled_pend <= 1'b0;
            end
            if (oled_take) begin
                col <= nxt_col;
                row <= nxt_row;
            end
            if (bus.oled_req && !oled_take)
                bus.oled_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed vectors, corner sequences and a random run against a queue-based reference.
module tb_fb_port_arbiter;
    localparam int FB_W       = 320;
    localparam int OLED_W     = 96;
    localparam int OLED_H     = 64;
    localparam int OLED_X0    = 112;
    localparam int OLED_Y0    = 88;
    localparam int STARVE_MAX = 8;
    localparam int N_OLED     = OLED_W * OLED_H;
    localparam int MEM_N      = 1 << 17;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;

    fb_port_arbiter_if #(.ADDR_W(17), .DATA_W(18)) bus ();
    fb_port_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Frame-buffer RAM: synchronous, one-cycle read latency, preloaded with addr+1.
    logic [17:0] ram_mem [MEM_N];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < MEM_N; i++) ram_mem[i] <= 18'(i + 1);
            ram_loaded <= 1'b1;
        end else if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    typedef struct {
        int          due;
        bit          is_vga;
        logic [17:0] data;
    } ev_t;

    typedef struct {
        logic vr; int vx; int vy; logic orq; logic wv; int wa;
        logic exp_rdy; logic exp_en; logic exp_we; int exp_addr;
    } vec_t;

    ev_t         evq[$];
    logic [17:0] model_mem [MEM_N];
    int          m_starve, m_pos, m_pend_pos, m_addr;
    bit          m_pend, m_overrun, m_en, m_we;
    logic [17:0] m_wdata, exp_vga_pix, exp_oled_pix;
    logic        rdy_seen;

    function automatic int oled_addr(input int p);
        return (p / OLED_W + OLED_Y0) * FB_W + (p % OLED_W) + OLED_X0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        evq.delete();
        m_starve = 0; m_pos = 0; m_pend_pos = 0; m_addr = 0;
        m_pend = 0; m_overrun = 0; m_en = 0; m_we = 0;
        m_wdata = '0; exp_vga_pix = '0; exp_oled_pix = '0;
    endtask

    task automatic check_outputs();
        bit ev_v = 1'b0;
        bit ev_o = 1'b0;
        if (evq.size() > 0 && evq[0].due == cyc) begin
            if (evq[0].is_vga) begin ev_v = 1'b1; exp_vga_pix = evq[0].data; end
            else begin ev_o = 1'b1; exp_oled_pix = evq[0].data; end
            void'(evq.pop_front());
        end
        chk("ram_en", 32'(bus.ram_en), 32'(m_en));
        if (m_en) begin
            chk("ram_we", 32'(bus.ram_we), 32'(m_we));
            chk("ram_addr", 32'(bus.ram_addr), m_addr);
            if (m_we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(m_wdata));
        end
        chk("vga_valid", 32'(bus.vga_valid), 32'(ev_v));
        chk("vga_pixel", 32'(bus.vga_pixel), 32'(exp_vga_pix));
        chk("oled_valid", 32'(bus.oled_valid), 32'(ev_o));
        chk("oled_pixel", 32'(bus.oled_pixel), 32'(exp_oled_pix));
        chk("oled_overrun", 32'(bus.oled_overrun), 32'(m_overrun));
    endtask

    // Reference: grant from the priority list, OLED scan as a linear pixel position.
    task automatic model_step();
        int g;
        int use_pos = 0;
        bit was_pend, take;
        ev_t e;
        g = 0;
        if (bus.vga_req)                                   g = 1;
        else if (bus.wr_valid && m_starve == STARVE_MAX)   g = 3;
        else if (m_pend || bus.oled_req)                   g = 2;
        else if (bus.wr_valid)                             g = 3;
        rdy_seen = bus.wr_ready;
        chk("wr_ready", 32'(bus.wr_ready), 32'(g == 3));

        was_pend = m_pend;
        take = bus.oled_req && (!was_pend || g == 2);
        if (bus.oled_req && !take) m_overrun = 1'b1;
        if (take) begin
            use_pos = (bus.oled_index == 13'd0) ? 0 : m_pos;
            m_pos = (use_pos + 1) % N_OLED;
        end

        m_en = (g != 0);
        m_we = (g == 3);
        case (g)
            1: begin
                m_addr = int'(bus.vga_y) * FB_W + int'(bus.vga_x);
                e.due = cyc + 3; e.is_vga = 1'b1; e.data = model_mem[m_addr];
                evq.push_back(e);
            end
            2: begin
                m_addr = oled_addr(was_pend ? m_pend_pos : use_pos);
                e.due = cyc + 3; e.is_vga = 1'b0; e.data = model_mem[m_addr];
                evq.push_back(e);
            end
            3: begin
                m_addr = int'(bus.wr_addr);
                m_wdata = bus.wr_data;
                model_mem[m_addr] = m_wdata;
            end
            default: ;
        endcase

        if (take && (was_pend || g != 2)) begin
            m_pend = 1'b1;
            m_pend_pos = use_pos;
        end else if (g == 2) begin
            m_pend = 1'b0;
        end
        if (bus.wr_valid && g != 3) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else                        m_starve = 0;
    endtask

    task automatic do_cycle(input logic vr, input int vx, input int vy, input logic orq, input int oi,
                            input logic wv, input int wa, input int wd);
        bus.vga_req = vr;  bus.vga_x = 9'(vx);       bus.vga_y = 9'(vy);
        bus.oled_req = orq; bus.oled_index = 13'(oi);
        bus.wr_valid = wv; bus.wr_addr = 17'(wa);    bus.wr_data = 18'(wd);
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input logic busy);
        reset_n = 1'b0;
        bus.vga_req = busy; bus.oled_req = busy; bus.wr_valid = busy;
        bus.vga_x = '0; bus.vga_y = '0; bus.oled_index = '0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_en", 32'(bus.ram_en), 0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 0);
        chk("rst_vga_valid", 32'(bus.vga_valid), 0);
        chk("rst_oled_valid", 32'(bus.oled_valid), 0);
        chk("rst_overrun", 32'(bus.oled_overrun), 0);
        bus.vga_req = 1'b0; bus.oled_req = 1'b0; bus.wr_valid = 1'b0;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[8];
        int   gap, ov_cnt;
        logic vr, orq, wv;
        int   oi;

        for (int i = 0; i < MEM_N; i++) model_mem[i] = 18'(i + 1);
        bus.vga_req = 1'b0; bus.vga_x = '0; bus.vga_y = '0;
        bus.oled_req = 1'b0; bus.oled_index = '0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        model_reset();

        // Reset with every requester active, then idle
        do_reset(1'b1);
        idle(3);
        chk("idle_ram_en", 32'(bus.ram_en), 0);
        chk("idle_vga_valid", 32'(bus.vga_valid), 0);

        //          vr  vx   vy  orq wv  wa    rdy en  we  addr
        vecs[0] = '{0,  0,   0,  0,  0,  0,    0,  0,  0,  0};
        vecs[1] = '{0,  0,   0,  0,  1,  1234, 1,  1,  1,  1234};
        vecs[2] = '{1,  5,   2,  0,  1,  999,  0,  1,  0,  645};
        vecs[3] = '{0,  0,   0,  1,  1,  999,  0,  1,  0,  28272};
        vecs[4] = '{1,  7,   0,  1,  0,  0,    0,  1,  0,  7};
        vecs[5] = '{1,  319, 239, 0, 0,  0,    0,  1,  0,  76799};
        vecs[6] = '{0,  0,   0,  1,  0,  0,    0,  1,  0,  28272};
        vecs[7] = '{1,  10,  1,  1,  1,  999,  0,  1,  0,  330};
        for (int v = 0; v < 8; v++) begin
            do_reset(1'b0);
            do_cycle(vecs[v].vr, vecs[v].vx, vecs[v].vy, vecs[v].orq, 0, vecs[v].wv, vecs[v].wa, 5000 + v);
            chk($sformatf("vec%0d_wr_ready", v), 32'(rdy_seen), 32'(vecs[v].exp_rdy));
            chk($sformatf("vec%0d_ram_en", v), 32'(bus.ram_en), 32'(vecs[v].exp_en));
            chk($sformatf("vec%0d_ram_we", v), 32'(bus.ram_we), 32'(vecs[v].exp_we));
            chk($sformatf("vec%0d_ram_addr", v), 32'(bus.ram_addr), vecs[v].exp_addr);
            idle(4);
        end

        // VGA read latency
        do_reset(1'b0);
        do_cycle(1, 5, 2, 0, 0, 0, 0, 0);
        chk("vga_addr", 32'(bus.ram_addr), 645);
        idle(1);
        chk("vga_valid_early", 32'(bus.vga_valid), 0);
        idle(1);
        chk("vga_valid_e2", 32'(bus.vga_valid), 1);
        chk("vga_pixel_e2", 32'(bus.vga_pixel), 646);
        idle(2);

        // VGA/OLED collision
        do_reset(1'b0);
        do_cycle(1, 0, 0, 1, 0, 0, 0, 0);
        chk("coll_vga_addr", 32'(bus.ram_addr), 0);
        idle(1);
        chk("coll_oled_addr", 32'(bus.ram_addr), 28272);
        idle(1);
        chk("coll_vga_valid", 32'(bus.vga_valid), 1);
        chk("coll_vga_pixel", 32'(bus.vga_pixel), 1);
        idle(1);
        chk("coll_oled_valid", 32'(bus.oled_valid), 1);
        chk("coll_oled_pixel", 32'(bus.oled_pixel), 28273);
        chk("coll_vga_done", 32'(bus.vga_valid), 0);
        idle(2);

        // OLED column wrap into the next row
        do_reset(1'b0);
        for (int i = 0; i < 97; i++) begin
            do_cycle(0, 0, 0, 1, i, 0, 0, 0);
            if (i == 95) chk("wrap_96th_addr", 32'(bus.ram_addr), 28367);
            if (i == 96) chk("wrap_97th_addr", 32'(bus.ram_addr), 28592);
        end
        idle(3);

        // Overrun: second request while the first is stuck behind VGA
        do_reset(1'b0);
        do_cycle(1, 1, 1, 1, 0, 0, 0, 0);
        do_cycle(1, 2, 1, 1, 0, 0, 0, 0);
        chk("overrun_set", 32'(bus.oled_overrun), 1);
        ov_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (bus.oled_valid) ov_cnt++;
        end
        chk("overrun_one_valid", ov_cnt, 1);
        chk("overrun_sticky", 32'(bus.oled_overrun), 1);

        // Write starvation against a continuous OLED stream
        do_reset(1'b0);
        for (int k = 1; k <= 9; k++) begin
            do_cycle(0, 0, 0, 1, k - 1, 1, 100000, 18'h2AAAA);
            chk($sformatf("starve_rdy_c%0d", k), 32'(rdy_seen), 32'(k == 9));
        end
        chk("starve_ram_we", 32'(bus.ram_we), 1);
        chk("starve_ram_addr", 32'(bus.ram_addr), 100000);
        chk("starve_ram_wdata", 32'(bus.ram_wdata), 32'h2AAAA);
        do_cycle(0, 0, 0, 0, 0, 1, 100001, 7);
        chk("starve_oled_next_rdy", 32'(rdy_seen), 0);
        chk("starve_oled_next_addr", 32'(bus.ram_addr), 28280);
        chk("starve_oled_next_we", 32'(bus.ram_we), 0);
        do_cycle(0, 0, 0, 0, 0, 1, 100001, 7);
        chk("starve_after_rdy", 32'(rdy_seen), 1);
        idle(4);

        // Random traffic against the reference, with a reset landing on in-flight reads
        do_reset(1'b0);
        gap = 4;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset(1'b0);
            vr  = ((gap >= 4) && ($urandom_range(0, 1) == 1)) || (n == 1498);
            gap = vr ? 1 : gap + 1;
            orq = ($urandom_range(0, 2) == 0);
            oi  = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, N_OLED - 1));
            wv  = ($urandom_range(0, 4) < 3);
            do_cycle(vr, int'($urandom_range(0, 319)), int'($urandom_range(0, 239)), orq, oi,
                     wv, int'($urandom_range(0, MEM_N - 1)), int'($urandom_range(0, 262143)));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
